// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command master.
//   - Command encodings carried in the top two bits of every frame.
//   - Frame and data widths.
//   - Controller state encoding, which is also exported on the debug port.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_TURN    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/spi_master_ram_ctrl_if.sv
// Request/response bundle between a requester and the SPI command master.
//   req_valid / req_ready / req_cmd / req_data : request channel
//   rsp_valid / rsp_data                       : read-byte response
//   busy                                       : controller is not idle
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. Once req_valid is raised the requester keeps it,
// req_cmd and req_data stable until that transfer; req_ready does not depend
// on req_valid. rsp_valid is a single-cycle strobe with no back-pressure;
// rsp_data keeps the last read byte until the next strobe.
interface spi_master_ram_ctrl_if;

  logic                       req_valid;
  logic                       req_ready;
  logic [1:0]                 req_cmd;
  logic [spi_pkg::DATA_W-1:0] req_data;
  logic                       rsp_valid;
  logic [spi_pkg::DATA_W-1:0] rsp_data;
  logic                       busy;

  // Requester side.
  modport master (
    output req_valid, req_cmd, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  // Controller side.
  modport slave (
    input  req_valid, req_cmd, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_master_shifter.sv
// Serial datapath of the SPI command master.
//   - 10-bit parallel-load transmit register, shifted out MSB first.
//   - 8-bit receive register filled MSB first from miso.
//   - Shared bit counter for both directions.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   load, load_frame : parallel load of the transmit register (clears counter)
//   shift_en         : advance the transmit register by one bit
//   cap_en           : shift miso into the receive register
//   cnt_clr          : clear the bit counter
//   miso             : serial input
//   mosi_bit         : current transmit bit
//   rx_next          : receive register including the current miso bit
//   bit_cnt          : bits moved since the last clear
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic              shift_en,
  input  logic              cap_en,
  input  logic              cnt_clr,
  input  logic              miso,
  output logic              mosi_bit,
  output logic [DATA_W-1:0] rx_next,
  output logic [3:0]        bit_cnt
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic [3:0]         cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load)
        tx_q <= load_frame;
      else if (shift_en)
        tx_q <= {tx_q[FRAME_W-2:0], 1'b0};

      if (cap_en)
        rx_q <= rx_next;

      if (cnt_clr || load)
        cnt_q <= '0;
      else if (shift_en || cap_en)
        cnt_q <= cnt_q + 4'd1;
    end
  end

  assign mosi_bit = tx_q[FRAME_W-1];
  // The last sample goes straight to the response register, so expose the
  // post-shift value rather than waiting a cycle for rx_q to settle.
  assign rx_next  = {rx_q[DATA_W-2:0], miso};
  assign bit_cnt  = cnt_q;

endmodule

// File: rtl/spi_master_ram_ctrl.sv
// SPI command master for the SPI slave + single-port RAM subsystem.
// Turns parallel requests into 10-bit {cmd, payload} frames, one bit per
// clk, and returns read bytes on a one-cycle response strobe.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   req_if    : request/response bundle (slave modport)
//   ss_n      : slave select, active low
//   MOSI      : serial data out, MSB first
//   MISO      : serial data in, sampled only while capturing
//   state_dbg : current controller state
// Parameters:
//   TURNAROUND : idle cycles between a read-data frame and the first MISO
//                sample (1..4)
//   IDLE_GAP   : minimum ss_n high cycles between frames (1..7)
// Build option:
//   SPI_MASTER_AUTO_READ_EN : a read-address request chains a read-data
//                             frame after its gap without a second handshake.
module spi_master_ram_ctrl
  import spi_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int IDLE_GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_ram_ctrl_if.slave req_if,
  output logic                 ss_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output state_t               state_dbg
);

  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [2:0] GAP_LAST  = 3'(IDLE_GAP - 1);
  localparam logic [FRAME_W-1:0] RD_FRAME = {CMD_RD_DATA, 8'h00};

  state_t             state_q, state_d;
  logic [2:0]         wait_q;
  logic               is_rd_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               auto_go;

  logic               load;
  logic [FRAME_W-1:0] load_frame;
  logic [FRAME_W-1:0] req_frame;
  logic               shift_en;
  logic               cap_en;
  logic               cnt_clr;
  logic               mosi_bit;
  logic [DATA_W-1:0]  rx_next;
  logic [3:0]         bit_cnt;
  logic               req_ready_c;
  logic               busy_c;

  // Read-data frames carry a zero payload whatever req_data holds.
  assign req_frame = (req_if.req_cmd == CMD_RD_DATA) ? RD_FRAME
                                                      : {req_if.req_cmd, req_if.req_data};

`ifdef SPI_MASTER_AUTO_READ_EN
  logic auto_pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      auto_pend_q <= 1'b0;
    else if (load && state_q == ST_IDLE)
      auto_pend_q <= (req_if.req_cmd == CMD_RD_ADDR);
    else if (load)
      auto_pend_q <= 1'b0;
  end

  assign auto_go = auto_pend_q;
`else
  assign auto_go = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_if.req_valid) state_d = ST_SHIFT;
      ST_SHIFT:   if (bit_cnt == 4'(FRAME_W - 1)) state_d = is_rd_q ? ST_TURN : ST_GAP;
      ST_TURN:    if (wait_q == TURN_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE: if (bit_cnt == 4'(DATA_W - 1)) state_d = ST_GAP;
      ST_GAP:     if (wait_q == GAP_LAST) state_d = auto_go ? ST_SHIFT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic. Everything here decodes the current state, so an
  // asynchronous reset releases the bus in the same instant.
  always_comb begin
    ss_n        = 1'b1;
    MOSI        = 1'b0;
    req_ready_c = 1'b0;
    busy_c      = 1'b1;
    load        = 1'b0;
    load_frame  = req_frame;
    shift_en    = 1'b0;
    cap_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        busy_c      = 1'b0;
        load        = req_if.req_valid;
      end
      ST_SHIFT: begin
        ss_n     = 1'b0;
        MOSI     = mosi_bit;
        shift_en = 1'b1;
      end
      ST_TURN: begin
        ss_n = 1'b0;
      end
      ST_CAPTURE: begin
        ss_n   = 1'b0;
        cap_en = 1'b1;
      end
      ST_GAP: begin
        if (wait_q == GAP_LAST && auto_go) begin
          load       = 1'b1;
          load_frame = RD_FRAME;
        end
      end
      default: begin
        busy_c = 1'b1;
      end
    endcase
  end

  assign cnt_clr = (state_d != state_q);

  // Per-state cycle counter for TURN and GAP, plus response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q      <= '0;
      is_rd_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wait_q <= (state_d != state_q) ? 3'd0 : wait_q + 3'd1;
      if (load)
        is_rd_q <= (load_frame[FRAME_W-1 -: 2] == CMD_RD_DATA);
      rsp_valid_q <= (state_q == ST_CAPTURE) && (bit_cnt == 4'(DATA_W - 1));
      if ((state_q == ST_CAPTURE) && (bit_cnt == 4'(DATA_W - 1)))
        rsp_data_q <= rx_next;
    end
  end

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_frame (load_frame),
    .shift_en   (shift_en),
    .cap_en     (cap_en),
    .cnt_clr    (cnt_clr),
    .miso       (MISO),
    .mosi_bit   (mosi_bit),
    .rx_next    (rx_next),
    .bit_cnt    (bit_cnt)
  );

  assign req_if.req_ready = req_ready_c;
  assign req_if.busy      = busy_c;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/spi_master_ram_ctrl.md
Name: spi_master_ram_ctrl

Overview:
- Command-side SPI master that sits directly upstream of the SPI slave + single-port RAM subsystem; drives ss_n/MOSI and samples MISO.
- Converts parallel request handshakes (write address, write data, read address, read data) into 10-bit SPI frames {cmd[1:0], payload[7:0]}.
- Returns read bytes on a response strobe.
- Runs on the same clock as the slave; one SPI bit per clk cycle, no clock division.

Parameters:
- TURNAROUND, 1, idle cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..4).
- IDLE_GAP, 1, minimum cycles ss_n stays high between frames (range 1..7).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_cmd  input  2  00 write addr, 01 write data, 10 read addr, 11 read data.
- req_data  input  8  address/data payload; ignored for cmd 11.
- rsp_valid  output  1  one-cycle pulse, read byte valid.
- rsp_data  output  8  read byte; holds its value until the next rsp_valid.
- busy  output  1  high whenever state != IDLE.
- ss_n  output  1  slave select to the slave, active-low.
- MOSI  output  1  serial data to the slave, MSB first.
- MISO  input  1  serial data from the slave.

Behaviour:
- Reset values: ss_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_data=0, busy=0, state=IDLE.
- Reset asserted mid-frame aborts immediately with the same values. No partial response is produced.
- States: IDLE, SHIFT, TURN, CAPTURE, GAP.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at edge T.
  - At T, latch shreg={req_cmd, req_data}, or {2'b11, 8'h00} for cmd 11. Go to SHIFT.
- SHIFT, cycles T+1..T+10:
  - ss_n=0; MOSI=shreg[9-k] on cycle T+1+k. Bit counter 0..9.
  - After bit 0: cmd 11 goes to TURN; otherwise goes to GAP.
- TURN: ss_n=0, MOSI=0, lasts TURNAROUND cycles, then go to CAPTURE.
- CAPTURE: ss_n=0, MOSI=0, 8 cycles.
  - MISO is sampled at the end of each cycle into rx[7:0], MSB first.
  - Cycle after the 8th sample: rsp_valid=1, rsp_data=rx, state moves to GAP.
- GAP: ss_n=1, MOSI=0, req_ready=0, lasts IDLE_GAP cycles, then returns to IDLE.
- Latency:
  - Write or read-address request: ss_n low for exactly 10 cycles.
  - Read data: ss_n low for 10+TURNAROUND+8 cycles; rsp_valid at T+11+TURNAROUND+8.
- req_ready=0 outside IDLE. req_valid while busy is ignored and must be held by the requester.
- Back-to-back requests: the next acceptance is at the earliest IDLE_GAP+1 cycles after ss_n rises.
- rsp_valid is never asserted for cmd 00/01/10.
- MISO is not sampled outside CAPTURE.

Optional Feature:
- Macro SPI_MASTER_AUTO_READ_EN.
- Defined: a cmd 10 request automatically chains a cmd 11 frame after the normal GAP, with no second handshake. busy and req_ready=0 are held across the whole sequence; one rsp_valid is produced at the end.
- Undefined: cmd 10 sends the address frame only. The requester issues cmd 11 separately.

Decomposition:
- Shared package spi_pkg:
  - Command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W=10, DATA_W=8.
  - State enum typedef.
- One sub-module spi_master_shifter:
  - 10-bit parallel-load MSB-first TX shift register plus 8-bit RX capture register with bit counter.
  - FSM stays in the top.

Test Plan:
- Reset with rst=0 for 3 cycles, release -> ss_n=1, MOSI=0, req_ready=1, rsp_valid=0.
- Request cmd 00, data 8'hA5 -> ss_n low 10 cycles; MOSI sequence 0,0,1,0,1,0,0,1,0,1; no rsp_valid.
- Request cmd 11 with slave model driving 8'h3C after TURNAROUND=1 -> rsp_valid single pulse at T+20, rsp_data=8'h3C, ss_n low 19 cycles.
- Full write/read loop against the slave+RAM pair:
  - Write addr 8'h12, write data 8'hC7, read addr 8'h12, read data -> rsp_data=8'hC7.
- req_valid held high continuously with four queued writes -> each accepted only in IDLE; ss_n high ≥IDLE_GAP cycles between frames.
- rst pulsed low at bit 5 of a read-data frame -> ss_n=1 and MOSI=0 immediately, no rsp_valid; next request completes normally.
